mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have clk  input  1  sole clock, all state on rising edge.
REQ-002 SHALL have rst  input  1  reset, asynchronous and active-high.
REQ-003 SHALL have EX_to_MEM  input  1  handoff pulse from EX; EX_to_MEM_zip  input  106  {pc[31:0], IR[31:0], gr_we, rf_waddr[4:0], alu_result[31:0], res_from_mem, ld_type[2:0]}.
REQ-004 SHALL have EX_except_zip  input  119  exception/CSR bundle from EX; MEM_except_zip  output  119  registered copy of it.
REQ-005 SHALL have MEM_allowin  output  1; WB_allowin  input  1; MEM_to_WB  output  1  handoff pulse to WB.
REQ-006 SHALL have MEM_to_WB_zip  output  103  {valid, pc, IR, gr_we, rf_waddr, rf_wdata}.
REQ-007 SHALL have data_sram_data_ok  input  1; data_sram_rdata  input  32  load response.
REQ-008 SHALL have flush  input  1  (wb_ex | ertn_flush from WB); mem_blocking  output  1  load in MEM awaiting data (ID stall).

Function
REQ-009 SHALL latch both zips and set valid when EX_to_MEM & MEM_allowin & ~flush.
REQ-010 SHALL implement states EMPTY, WAIT_DATA, READY: EMPTY->WAIT_DATA on load accept (res_from_mem=1), EMPTY->READY on non-load accept; WAIT_DATA->READY on delivered data_ok; READY->EMPTY on MEM_to_WB without new accept, READY->WAIT_DATA/READY on MEM_to_WB with same-cycle accept.
REQ-011 SHALL drive MEM_allowin = (state==EMPTY) | (state==READY & WB_allowin).
REQ-012 SHALL drive MEM_to_WB = (state==READY) & WB_allowin & ~flush, combinationally.
REQ-013 SHALL capture data_sram_rdata in a 32-bit buffer on the delivered data_ok; rf_wdata SHALL be taken from the buffer, never the live bus, so a WB stall holds data stable.
REQ-014 SHALL align loads by alu_result[1:0]: ld_type 000 word, 001 byte signed, 010 half signed, 011 byte zero, 100 half zero; half uses alu_result[1] only; other codes yield rf_wdata = alu_result.
REQ-015 SHALL pass rf_wdata = alu_result when res_from_mem=0.
REQ-016 SHALL assert mem_blocking iff state==WAIT_DATA.
REQ-017 SHALL on flush go to EMPTY next cycle, drop valid, and block any same-cycle accept (flush wins).
REQ-018 SHALL, if flush occurs in WAIT_DATA, increment a 2-bit saturating discard counter; a data_ok while counter≠0 SHALL decrement it and SHALL NOT be delivered or buffered.
REQ-019 SHALL deliver a data_ok arriving with counter==0 only in WAIT_DATA; a data_ok in any other state is ignored.
REQ-020 SHALL treat simultaneous flush and data_ok in WAIT_DATA as: data discarded, counter unchanged.

Reset
REQ-021 SHALL on rst force state EMPTY, valid 0, discard counter 0, buffer 0, both output zips 0, MEM_to_WB 0, mem_blocking 0; MEM_allowin SHALL read 1.
REQ-022 SHALL abandon any in-flight load on rst without tracking its response.

Configuration
REQ-023 SHALL support macro MEM_FWD_EN: when defined, add output mem_fwd[37:0] = {fwd_valid, rf_waddr, rf_wdata}, fwd_valid = valid & gr_we & (state==READY) & ~flush; when undefined, the port does not exist and ID relies on mem_blocking/stall only.

Structure
REQ-024 SHALL keep ld_type codes, zip widths and state encodings in the shared macros header alongside ECODE definitions.
REQ-025 SHALL place load alignment/extension in combinational sub-module mem_load_align (inputs rdata, addr[1:0], ld_type; output 32-bit result).

Verification
REQ-026 Non-load add, pc=0x1c000010, waddr=5, alu_result=0x1234, WB_allowin=1 -> MEM_to_WB one cycle later, zip rf_wdata=0x1234, valid=1.
REQ-027 ld.b addr low=2'b11, rdata=0x80FF_0000 after 3-cycle wait -> mem_blocking high 3 cycles, rf_wdata=0xFFFF_FF80; ld.bu same -> 0x0000_0080.
REQ-028 ld.h addr=...10, rdata=0x7FFF_1234, data_ok while WB_allowin=0 for 4 cycles -> rf_wdata stays 0x0000_7FFF, MEM_to_WB fires in the cycle WB_allowin rises.
REQ-029 Flush in WAIT_DATA, then new load accepted, then two data_ok (0xAAAA_AAAA then 0x5555_5555) -> first discarded, new load returns 0x5555_5555.
REQ-030 rst asserted mid-WAIT_DATA, asynchronously -> all outputs 0 immediately, MEM_allowin=1, state EMPTY.
REQ-031 With MEM_FWD_EN: load in READY waddr=7, rdata=0x42 word -> mem_fwd=={1,7,0x42}; during flush fwd_valid=0.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: zip widths, load-type codes, FSM states, exception codes.
package mem_stage_pkg;

  localparam int EX_TO_MEM_W = 106;
  localparam int EXCEPT_W    = 119;
  localparam int MEM_TO_WB_W = 103;

  localparam logic [2:0] LD_W  = 3'b000;
  localparam logic [2:0] LD_B  = 3'b001;
  localparam logic [2:0] LD_H  = 3'b010;
  localparam logic [2:0] LD_BU = 3'b011;
  localparam logic [2:0] LD_HU = 3'b100;

  localparam logic [5:0] ECODE_INT = 6'h00;
  localparam logic [5:0] ECODE_ADE = 6'h08;
  localparam logic [5:0] ECODE_ALE = 6'h09;
  localparam logic [5:0] ECODE_SYS = 6'h0b;
  localparam logic [5:0] ECODE_BRK = 6'h0c;
  localparam logic [5:0] ECODE_INE = 6'h0d;

  typedef enum logic [1:0] {
    S_EMPTY     = 2'd0,
    S_WAIT_DATA = 2'd1,
    S_READY     = 2'd2
  } mem_state_e;

  // Field order matches the EX_to_MEM_zip bit layout, MSB first.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
    logic        gr_we;
    logic [4:0]  rf_waddr;
    logic [31:0] alu_result;
    logic        res_from_mem;
    logic [2:0]  ld_type;
  } ex_mem_t;

  function automatic logic ld_type_known(input logic [2:0] t);
    return (t <= LD_HU);
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data alignment and sign/zero extension by address low bits and load type.
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  ld_type,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{addr, 3'b000} +: 8];
    // Halfwords are assumed aligned; addr[0] is ignored.
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
    case (ld_type)
      LD_B:    result = {{24{byte_sel[7]}}, byte_sel};
      LD_BU:   result = {24'h0, byte_sel};
      LD_H:    result = {{16{half_sel[15]}}, half_sel};
      LD_HU:   result = {16'h0, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: holds one EX handoff, waits for load data, aligns it and hands off to WB.
// Optional forwarding port enabled by defining MEM_FWD_EN.
//
// state       | meaning
// S_EMPTY     | no instruction held, always accepts
// S_WAIT_DATA | load held, waiting for its data_ok (mem_blocking high)
// S_READY     | result available, handed to WB when WB_allowin
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   EX_to_MEM,
  input  logic [EX_TO_MEM_W-1:0] EX_to_MEM_zip,
  input  logic [EXCEPT_W-1:0]    EX_except_zip,
  output logic [EXCEPT_W-1:0]    MEM_except_zip,
  output logic                   MEM_allowin,
  input  logic                   WB_allowin,
  output logic                   MEM_to_WB,
  output logic [MEM_TO_WB_W-1:0] MEM_to_WB_zip,
  input  logic                   data_sram_data_ok,
  input  logic [31:0]            data_sram_rdata,
  input  logic                   flush,
  output logic                   mem_blocking
`ifdef MEM_FWD_EN
  ,
  output logic [37:0]            mem_fwd
`endif
);

  mem_state_e          state_q, state_d;
  logic                valid_q, valid_d;
  ex_mem_t             ex_q, ex_d;
  logic [EXCEPT_W-1:0] except_q, except_d;
  logic [31:0]         dbuf_q, dbuf_d;
  logic [1:0]          discard_q, discard_d;

  logic        accept;
  logic        to_wb;
  logic        flush_wait;
  logic        deliver;
  logic [31:0] aligned;
  logic [31:0] rf_wdata;

  assign MEM_allowin  = (state_q == S_EMPTY) | ((state_q == S_READY) & WB_allowin);
  assign accept       = EX_to_MEM & MEM_allowin & ~flush;
  assign to_wb        = (state_q == S_READY) & WB_allowin & ~flush;
  assign flush_wait   = flush & (state_q == S_WAIT_DATA);
  // A response is ours only if nothing older is still owed to the discard counter.
  assign deliver      = data_sram_data_ok & (discard_q == 2'd0) & (state_q == S_WAIT_DATA) & ~flush;
  assign MEM_to_WB    = to_wb;
  assign mem_blocking = (state_q == S_WAIT_DATA);

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    ex_d      = ex_q;
    except_d  = except_q;
    dbuf_d    = dbuf_q;
    discard_d = discard_q;

    if (accept) begin
      ex_d     = ex_mem_t'(EX_to_MEM_zip);
      except_d = EX_except_zip;
    end
    if (deliver) dbuf_d = data_sram_rdata;

    // Flush with a same-cycle data_ok: the response is consumed here, so nothing new is owed.
    if (flush_wait && !data_sram_data_ok) begin
      if (discard_q != 2'd3) discard_d = discard_q + 2'd1;
    end else if (!flush_wait && data_sram_data_ok && discard_q != 2'd0) begin
      discard_d = discard_q - 2'd1;
    end

    if (flush) begin
      state_d = S_EMPTY;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (accept) begin
            state_d = EX_to_MEM_zip[3] ? S_WAIT_DATA : S_READY;
            valid_d = 1'b1;
          end
        end
        S_WAIT_DATA: begin
          if (deliver) state_d = S_READY;
        end
        S_READY: begin
          if (to_wb) begin
            if (accept) begin
              state_d = EX_to_MEM_zip[3] ? S_WAIT_DATA : S_READY;
              valid_d = 1'b1;
            end else begin
              state_d = S_EMPTY;
              valid_d = 1'b0;
            end
          end
        end
        default: begin
          state_d = S_EMPTY;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_EMPTY;
      valid_q   <= 1'b0;
      ex_q      <= '0;
      except_q  <= '0;
      dbuf_q    <= '0;
      discard_q <= 2'd0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      ex_q      <= ex_d;
      except_q  <= except_d;
      dbuf_q    <= dbuf_d;
      discard_q <= discard_d;
    end
  end

  mem_load_align u_align (
    .rdata   (dbuf_q),
    .addr    (ex_q.alu_result[1:0]),
    .ld_type (ex_q.ld_type),
    .result  (aligned)
  );

  assign rf_wdata = (ex_q.res_from_mem && ld_type_known(ex_q.ld_type)) ? aligned : ex_q.alu_result;

  assign MEM_except_zip = except_q;
  assign MEM_to_WB_zip  = {valid_q, ex_q.pc, ex_q.ir, ex_q.gr_we, ex_q.rf_waddr, rf_wdata};

`ifdef MEM_FWD_EN
  assign mem_fwd = {valid_q & ex_q.gr_we & (state_q == S_READY) & ~flush, ex_q.rf_waddr, rf_wdata};
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed stimulus pushes expected WB zips, a negedge monitor checks them.
module tb_mem_stage;

  logic         clk;
  logic         rst;
  logic         EX_to_MEM;
  logic [105:0] EX_to_MEM_zip;
  logic [118:0] EX_except_zip;
  logic [118:0] MEM_except_zip;
  logic         MEM_allowin;
  logic         WB_allowin;
  logic         MEM_to_WB;
  logic [102:0] MEM_to_WB_zip;
  logic         data_sram_data_ok;
  logic [31:0]  data_sram_rdata;
  logic         flush;
  logic         mem_blocking;
`ifdef MEM_FWD_EN
  logic [37:0]  mem_fwd;
`endif

  mem_stage dut (
    .clk               (clk),
    .rst               (rst),
    .EX_to_MEM         (EX_to_MEM),
    .EX_to_MEM_zip     (EX_to_MEM_zip),
    .EX_except_zip     (EX_except_zip),
    .MEM_except_zip    (MEM_except_zip),
    .MEM_allowin       (MEM_allowin),
    .WB_allowin        (WB_allowin),
    .MEM_to_WB         (MEM_to_WB),
    .MEM_to_WB_zip     (MEM_to_WB_zip),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .flush             (flush),
    .mem_blocking      (mem_blocking)
`ifdef MEM_FWD_EN
    ,
    .mem_fwd           (mem_fwd)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [102:0] sb [$];
  logic [102:0] mon_exp;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && MEM_to_WB) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_handoff: got zip %0h expected no handoff", MEM_to_WB_zip);
      end else begin
        mon_exp = sb.pop_front();
        chk("handoff_zip", MEM_to_WB_zip, mon_exp);
      end
    end
  end

  // Tasks start and end at 1ns after a rising edge.
  task automatic issue(input logic [31:0] pc, input logic [4:0] waddr, input logic [31:0] alu,
                       input logic ld, input logic [2:0] ldt, input logic push,
                       input logic [31:0] exp_wdata);
    logic [31:0]  ir;
    logic [118:0] exc;
    ir  = pc ^ 32'h0F0F_0000;
    exc = {55'h0, pc, ~pc};
    EX_to_MEM     = 1'b1;
    EX_to_MEM_zip = {pc, ir, 1'b1, waddr, alu, ld, ldt};
    EX_except_zip = exc;
    if (push) sb.push_back({1'b1, pc, ir, 1'b1, waddr, exp_wdata});
    @(negedge clk);
    chk("allowin_at_issue", MEM_allowin, 1'b1);
    @(posedge clk);
    #1;
    EX_to_MEM     = 1'b0;
    EX_except_zip = '0;
    chk("except_zip", MEM_except_zip, exc);
  endtask

  task automatic give_data(input logic [31:0] d);
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = d;
    @(posedge clk);
    #1;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'hDEAD_BEEF;
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("scoreboard_drained", sb.size(), 0);
  endtask

  logic [31:0] t_alu [8] = '{32'h1c00_0100, 32'h1c00_0101, 32'h1c00_0100, 32'h1c00_0101,
                             32'h1c00_0102, 32'h1c00_0103, 32'h1c00_0205, 32'h1c00_0203};
  logic [2:0]  t_ldt [8] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b011, 3'b010, 3'b101, 3'b001};
  logic        t_ld  [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [31:0] t_rd  [8] = '{32'h89AB_CDEF, 32'h0000_7F00, 32'h1234_8001, 32'h1234_8001,
                             32'h00AB_0000, 32'h8000_1234, 32'hFFFF_FFFF, 32'h0};
  logic [31:0] t_exp [8] = '{32'h89AB_CDEF, 32'h0000_007F, 32'hFFFF_8001, 32'h0000_8001,
                             32'h0000_00AB, 32'hFFFF_8000, 32'h1c00_0205, 32'h1c00_0203};

  initial begin
    rst               = 1'b1;
    EX_to_MEM         = 1'b0;
    EX_to_MEM_zip     = '0;
    EX_except_zip     = '0;
    WB_allowin        = 1'b1;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = '0;
    flush             = 1'b0;

    #2;
    chk("rst_allowin", MEM_allowin, 1'b1);
    chk("rst_to_wb", MEM_to_WB, 1'b0);
    chk("rst_blocking", mem_blocking, 1'b0);
    chk("rst_wb_zip", MEM_to_WB_zip, 103'h0);
    chk("rst_except_zip", MEM_except_zip, 119'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Non-load add handed off the cycle after acceptance.
    issue(32'h1c00_0010, 5'd5, 32'h0000_1234, 1'b0, 3'b000, 1'b1, 32'h0000_1234);
    @(negedge clk);
    chk("nonload_to_wb", MEM_to_WB, 1'b1);
    @(posedge clk);
    #1;
    wait_drain();

    // ld.b / ld.bu at byte 3 with three blocking cycles.
    for (int v = 0; v < 2; v++) begin
      issue(32'h1c00_0020 + v, 5'd6, 32'h1c00_0203, 1'b1, (v == 0) ? 3'b001 : 3'b011, 1'b1,
            (v == 0) ? 32'hFFFF_FF80 : 32'h0000_0080);
      repeat (2) begin
        @(negedge clk);
        chk("ldb_blocking", mem_blocking, 1'b1);
        @(posedge clk);
        #1;
      end
      @(negedge clk);
      chk("ldb_blocking_last", mem_blocking, 1'b1);
      give_data(32'h80FF_0000);
      @(negedge clk);
      chk("ldb_unblocked", mem_blocking, 1'b0);
      @(posedge clk);
      #1;
      wait_drain();
    end

    // ld.h upper half while WB stalls: buffered data must hold against a changing bus.
    WB_allowin = 1'b0;
    issue(32'h1c00_0030, 5'd8, 32'h1c00_0302, 1'b1, 3'b010, 1'b1, 32'h0000_7FFF);
    @(posedge clk);
    #1;
    give_data(32'h7FFF_1234);
    repeat (4) begin
      @(negedge clk);
      chk("stall_no_handoff", MEM_to_WB, 1'b0);
      chk("stall_wdata_held", MEM_to_WB_zip[31:0], 32'h0000_7FFF);
      @(posedge clk);
      #1;
    end
    WB_allowin = 1'b1;
    @(negedge clk);
    chk("stall_release_handoff", MEM_to_WB, 1'b1);
    @(posedge clk);
    #1;
    wait_drain();

    // Flush in WAIT_DATA; the stale response must be discarded.
    issue(32'h1c00_0040, 5'd9, 32'h1c00_0400, 1'b1, 3'b000, 1'b0, 32'h0);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_wait_allowin", MEM_allowin, 1'b0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_unblocked", mem_blocking, 1'b0);
    chk("flush_valid_dropped", MEM_to_WB_zip[102], 1'b0);
    @(posedge clk);
    #1;
    issue(32'h1c00_0044, 5'd10, 32'h1c00_0404, 1'b1, 3'b000, 1'b1, 32'h5555_5555);
    give_data(32'hAAAA_AAAA);
    @(negedge clk);
    chk("stale_discarded_still_blocking", mem_blocking, 1'b1);
    @(posedge clk);
    #1;
    give_data(32'h5555_5555);
    wait_drain();

    // Flush beats a same-cycle accept.
    EX_to_MEM     = 1'b1;
    EX_to_MEM_zip = {32'h1c00_0050, 32'h0, 1'b1, 5'd3, 32'h1c00_0500, 1'b1, 3'b000};
    flush         = 1'b1;
    @(posedge clk);
    #1;
    EX_to_MEM = 1'b0;
    flush     = 1'b0;
    @(negedge clk);
    chk("flush_blocks_accept_state", mem_blocking, 1'b0);
    chk("flush_blocks_accept_valid", MEM_to_WB_zip[102], 1'b0);
    @(posedge clk);
    #1;

    // Flush in READY suppresses the handoff.
    WB_allowin = 1'b0;
    issue(32'h1c00_0060, 5'd4, 32'h0000_0060, 1'b0, 3'b000, 1'b0, 32'h0);
    flush      = 1'b1;
    WB_allowin = 1'b1;
    @(negedge clk);
    chk("flush_ready_no_handoff", MEM_to_WB, 1'b0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_ready_valid", MEM_to_WB_zip[102], 1'b0);
    @(posedge clk);
    #1;

    // Flush and data_ok together in WAIT_DATA leave nothing owed.
    issue(32'h1c00_0070, 5'd11, 32'h1c00_0700, 1'b1, 3'b000, 1'b0, 32'h0);
    flush             = 1'b1;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h1111_1111;
    @(posedge clk);
    #1;
    flush             = 1'b0;
    data_sram_data_ok = 1'b0;
    issue(32'h1c00_0074, 5'd12, 32'h1c00_0704, 1'b1, 3'b000, 1'b1, 32'h0000_0077);
    give_data(32'h0000_0077);
    wait_drain();

    // Table of alignment/extension cases including unknown ld_type and non-load.
    for (int i = 0; i < 8; i++) begin
      issue(32'h1c00_1000 + 32'(i * 4), 5'(i + 13), t_alu[i], t_ld[i], t_ldt[i], 1'b1, t_exp[i]);
      if (t_ld[i]) give_data(t_rd[i]);
      wait_drain();
    end

    // Back-to-back non-loads: READY hands off and accepts in the same cycle.
    issue(32'h1c00_2000, 5'd1, 32'h0000_A001, 1'b0, 3'b000, 1'b1, 32'h0000_A001);
    issue(32'h1c00_2004, 5'd2, 32'h0000_A002, 1'b0, 3'b000, 1'b1, 32'h0000_A002);
    wait_drain();

`ifdef MEM_FWD_EN
    WB_allowin = 1'b0;
    issue(32'h1c00_3000, 5'd7, 32'h1c00_3000, 1'b1, 3'b000, 1'b0, 32'h0);
    give_data(32'h0000_0042);
    @(negedge clk);
    chk("fwd_ready", mem_fwd, {1'b1, 5'd7, 32'h0000_0042});
    @(posedge clk);
    #1;
    flush = 1'b1;
    #1;
    chk("fwd_flush_invalid", mem_fwd[37], 1'b0);
    @(posedge clk);
    #1;
    flush      = 1'b0;
    WB_allowin = 1'b1;
`endif

    // Asynchronous reset in WAIT_DATA; the abandoned response is then ignored.
    issue(32'h1c00_4000, 5'd20, 32'h1c00_4000, 1'b1, 3'b000, 1'b0, 32'h0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_blocking", mem_blocking, 1'b0);
    chk("async_rst_allowin", MEM_allowin, 1'b1);
    chk("async_rst_to_wb", MEM_to_WB, 1'b0);
    chk("async_rst_wb_zip", MEM_to_WB_zip, 103'h0);
    chk("async_rst_except_zip", MEM_except_zip, 119'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    give_data(32'h1234_5678);
    @(negedge clk);
    chk("post_rst_data_ignored", MEM_to_WB, 1'b0);
    chk("post_rst_empty", mem_blocking, 1'b0);
    @(posedge clk);
    #1;
    issue(32'h1c00_4004, 5'd21, 32'h1c00_4004, 1'b1, 3'b000, 1'b1, 32'h0000_0009);
    give_data(32'h0000_0009);
    wait_drain();

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
